// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, data width, FSM state encoding and funct3 legality helper for the load/store adapter
package lsu_pkg;
  localparam int DATA_W = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;
  // Unsigned widths only make sense for loads; stores of BU/HU are rejected.
  function automatic logic f3_legal(input logic [2:0] f3, input logic st);
    return (f3 == F3_B || f3 == F3_H || f3 == F3_W) || (!st && (f3 == F3_BU || f3 == F3_HU));
  endfunction
endpackage

// File: rtl/lsu_mem_adapter_if.sv
// lsu_mem_adapter_if: word-addressed cache bus; master = adapter (read/write/addr/wdata), slave = memory (rdata/stall)
interface lsu_mem_adapter_if import lsu_pkg::*; #(parameter int ADDR_W = 12);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_word_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  modport master (output mem_read, mem_write, mem_word_addr, mem_wdata, input mem_rdata, mem_stall);
  modport slave  (input mem_read, mem_write, mem_word_addr, mem_wdata, output mem_rdata, mem_stall);
endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: extracts/extends a load lane from word and merges sub-word store data into word (off = addr[1:0])
module lsu_byte_lane import lsu_pkg::*; (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        f3,
  input  logic [15:0]       sdata,
  output logic [DATA_W-1:0] ld,
  output logic [DATA_W-1:0] st
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    sh = {off, 3'b000};
    b  = 8'(word >> sh);
    h  = off[1] ? word[31:16] : word[15:0];
    ld = f3 == F3_B  ? {{24{b[7]}}, b} :
         f3 == F3_H  ? {{16{h[15]}}, h} :
         f3 == F3_BU ? {24'b0, b} :
         f3 == F3_HU ? {16'b0, h} : word;
    // Only SB (f3[0]=0) and SH (f3[0]=1) reach the merge path.
    st = f3[0] ? (off[1] ? {sdata, word[15:0]} : {word[31:16], sdata}) :
                 (word & ~(32'hFF << sh)) | ({24'b0, sdata[7:0]} << sh);
  end
endmodule

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter: turns byte-addressed core loads/stores into word cache accesses (RMW for SB/SH)
// Ports: clk, rst (async active-low); core_rd/core_wr/core_funct3/core_addr/core_wdata in;
//        core_stall (comb), load_data, misalign_err out; mem = cache bus master (registered outputs).
module lsu_mem_adapter import lsu_pkg::*; #(parameter int ADDR_W = 12) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign_err,
  lsu_mem_adapter_if.master mem
);
  state_t            state_q, state_d;
  logic              rd_q, rd_d, wr_q, wr_d, err_q, err_d, st_q, st_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, ldata_q, ldata_d, lane_ld, lane_st;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       sdata_q, sdata_d;
  logic              req, legal;
  lsu_byte_lane u_lane (
    .word  (mem.mem_rdata),
    .off   (off_q),
    .f3    (f3_q),
    .sdata (sdata_q),
    .ld    (lane_ld),
    .st    (lane_st)
  );
  assign req   = core_rd | core_wr;
  assign legal = f3_legal(core_funct3, core_wr) &&
                 !((core_funct3[1:0] == 2'b01 && core_addr[0]) || (core_funct3 == F3_W && core_addr[1:0] != 2'b00));
  assign core_stall        = state_q == IDLE ? req && legal : state_q != RESP;
  assign load_data         = ldata_q;
  assign misalign_err      = err_q;
  assign mem.mem_read      = rd_q;
  assign mem.mem_write     = wr_q;
  assign mem.mem_word_addr = addr_q;
  assign mem.mem_wdata     = wdata_q;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    st_d    = st_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    sdata_d = sdata_q;
    case (state_q)
      IDLE: if (req) begin
        if (!legal) err_d = 1'b1;
        else begin
          // A store wins over a simultaneous load; the request is latched so the core's hold is not relied on.
          st_d    = core_wr;
          addr_d  = core_addr[ADDR_W-1:2];
          f3_d    = core_funct3;
          off_d   = core_addr[1:0];
          sdata_d = core_wdata[15:0];
          if (core_wr && core_funct3 == F3_W) begin
            wdata_d = core_wdata;
            wr_d    = 1'b1;
            state_d = WR_ISSUE;
          end else begin
            rd_d    = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: if (!mem.mem_stall) begin
        rd_d = 1'b0;
        if (st_q) begin
          wdata_d = lane_st;
          wr_d    = 1'b1;
          state_d = WR_ISSUE;
        end else begin
          ldata_d = lane_ld;
          state_d = RESP;
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: if (!mem.mem_stall) begin
        wr_d    = 1'b0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      sdata_q <= sdata_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// tb_lsu_mem_adapter: directed + random load/store checks against a word-array reference model
module tb_lsu_mem_adapter;
  import lsu_pkg::*;
  logic        clk = 0, rst = 0, core_rd = 0, core_wr = 0, core_stall, misalign_err;
  logic [2:0]  core_funct3 = 0;
  logic [11:0] core_addr = 0;
  logic [31:0] core_wdata = 0, load_data;
  logic [31:0] bus_mem [1024];
  logic [31:0] ref_mem [1024];
  int tests = 0, fails = 0, krd = 0, kwr = 0, rd_cnt = 0, wr_cnt = 0, kind = 0, prev_kind = 0, cyc = 0;
  logic [9:0]  rd_addr = 0, wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic        both_seen = 0;
  lsu_mem_adapter_if #(.ADDR_W(12)) mif ();
  lsu_mem_adapter #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .core_rd(core_rd), .core_wr(core_wr), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
    .load_data(load_data), .misalign_err(misalign_err), .mem(mif)
  );
  always #5 clk = ~clk;
  assign mif.mem_rdata = bus_mem[mif.mem_word_addr];
  // Memory responder: first request cycle gets a random (ignored) stall, then krd/kwr stalled cycles.
  always @(negedge clk) begin
    kind = mif.mem_read ? 1 : mif.mem_write ? 2 : 0;
    if (mif.mem_read && mif.mem_write) both_seen = 1;
    if (kind != prev_kind) begin
      cyc = 0;
      if (kind == 1) begin rd_cnt++; rd_addr = mif.mem_word_addr; end
      if (kind == 2) begin wr_cnt++; wr_addr = mif.mem_word_addr; wr_data = mif.mem_wdata; end
    end else cyc++;
    mif.mem_stall = (kind == 0 || cyc == 0) ? 1'($urandom_range(0, 1)) : (cyc <= (kind == 1 ? krd : kwr));
    if (kind == 2 && !mif.mem_stall) bus_mem[mif.mem_word_addr] = mif.mem_wdata;
    prev_kind = kind;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic wr, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                       input int kr, input int kw, input string tag);
    int nb, off, lat, n, rd0, wr0;
    logic legal;
    logic [31:0] word, exp_ld, exp_st;
    logic [63:0] u, m, s;
    nb    = 8 << int'(f3[1:0]);
    off   = int'(a[1:0]);
    legal = (f3 inside {F3_B, F3_H, F3_W} || (!wr && f3 inside {F3_BU, F3_HU})) && (int'(a) % (nb / 8) == 0);
    word  = ref_mem[a[11:2]];
    m     = (64'd1 << nb) - 1;
    u     = ({32'b0, word} >> (8 * off)) & m;
    if (!f3[2] && nb < 32 && u[nb-1]) u = u - (64'd1 << nb);
    exp_ld = u[31:0];
    s      = ({32'b0, word} & ~(m << (8 * off))) | (({32'b0, wd} & m) << (8 * off));
    exp_st = s[31:0];
    lat    = !wr ? 3 + kr : (f3 == F3_W ? 3 + kw : 5 + kr + kw);
    krd = kr; kwr = kw; rd0 = rd_cnt; wr0 = wr_cnt;
    core_wr = wr; core_rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    core_funct3 = f3; core_addr = a; core_wdata = wd;
    #1 chk({tag, ".stall0"}, 32'(core_stall), 32'(legal));
    if (!legal) begin
      @(posedge clk); #1;
      chk({tag, ".err"}, 32'(misalign_err), 1);
      chk({tag, ".noreq"}, 32'(mif.mem_read | mif.mem_write), 0);
      core_rd = 0; core_wr = 0;
      @(posedge clk); #1;
      chk({tag, ".err_pulse"}, 32'(misalign_err), 0);
      chk({tag, ".rdcnt"}, rd_cnt, rd0);
      @(negedge clk);
    end else begin
      n = 0;
      do begin @(posedge clk); n++; #1; end while (core_stall && n < 40);
      chk({tag, ".lat"}, n, lat);
      if (!wr) begin
        chk({tag, ".ld"}, load_data, exp_ld);
        chk({tag, ".rdaddr"}, 32'(rd_addr), 32'(a[11:2]));
        chk({tag, ".wrcnt"}, wr_cnt, wr0);
      end else begin
        chk({tag, ".wrcnt"}, wr_cnt, wr0 + 1);
        chk({tag, ".wraddr"}, 32'(wr_addr), 32'(a[11:2]));
        chk({tag, ".wrdata"}, wr_data, exp_st);
        chk({tag, ".rdcnt"}, rd_cnt, rd0 + (f3 == F3_W ? 0 : 1));
        ref_mem[a[11:2]] = exp_st;
      end
      core_rd = 0; core_wr = 0;
      @(negedge clk); @(negedge clk);
      chk({tag, ".idle"}, 32'(core_stall), 0);
    end
  endtask
  initial begin
    int r0;
    for (int i = 0; i < 1024; i++) begin bus_mem[i] = $urandom; ref_mem[i] = bus_mem[i]; end
    bus_mem[4] = 32'h80FF_1234; ref_mem[4] = 32'h80FF_1234;
    bus_mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
    #1;
    chk("rst.read", 32'(mif.mem_read), 0);
    chk("rst.write", 32'(mif.mem_write), 0);
    chk("rst.addr", 32'(mif.mem_word_addr), 0);
    chk("rst.wdata", mif.mem_wdata, 0);
    chk("rst.ld", load_data, 0);
    chk("rst.err", 32'(misalign_err), 0);
    chk("rst.stall", 32'(core_stall), 0);
    @(negedge clk); rst = 1; @(negedge clk);
    do_op(0, F3_B, 12'h013, 0, 0, 0, "lb");
    chk("lb.const", load_data, 32'hFFFF_FF80);
    do_op(0, F3_HU, 12'h012, 0, 0, 0, "lhu");
    chk("lhu.const", load_data, 32'h0000_80FF);
    do_op(0, F3_H, 12'h012, 0, 0, 0, "lh");
    chk("lh.const", load_data, 32'hFFFF_80FF);
    do_op(1, F3_B, 12'h021, 32'h0000_00AB, 0, 0, "sb");
    chk("sb.const", wr_data, 32'h1122_AB44);
    chk("sb.addr", 32'(wr_addr), 8);
    do_op(1, F3_W, 12'h024, 32'hCAFE_F00D, 0, 4, "sw_stall");
    r0 = rd_cnt;
    do_op(0, F3_W, 12'h006, 0, 0, 0, "lw_mis");
    do_op(0, F3_H, 12'h003, 0, 0, 0, "lh_mis");
    do_op(1, F3_BU, 12'h040, 32'h12, 0, 0, "sbu_ill");
    chk("mis.noread", rd_cnt, r0);
    krd = 6; kwr = 0;
    core_wr = 1; core_rd = 0; core_funct3 = F3_H; core_addr = 12'h02A; core_wdata = 32'h5555;
    @(posedge clk); @(posedge clk); #2;
    chk("arst.pre_read", 32'(mif.mem_read), 1);
    rst = 0; #1;
    chk("arst.read", 32'(mif.mem_read), 0);
    chk("arst.write", 32'(mif.mem_write), 0);
    chk("arst.addr", 32'(mif.mem_word_addr), 0);
    chk("arst.wdata", mif.mem_wdata, 0);
    chk("arst.ld", load_data, 0);
    chk("arst.err", 32'(misalign_err), 0);
    core_wr = 0; #1;
    chk("arst.stall", 32'(core_stall), 0);
    @(negedge clk); rst = 1; @(negedge clk);
    chk("arst.mem", bus_mem[10], ref_mem[10]);
    do_op(0, F3_W, 12'h030, 0, 1, 0, "lw_post");
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [11:0] a;
      f = 3'($urandom_range(0, 7));
      a = 12'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = f[1] ? 2'b00 : f[0] ? {a[1], 1'b0} : a[1:0];
      do_op(1'($urandom_range(0, 1)), f, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
    end
    chk("rw_exclusive", 32'(both_seen), 0);
    for (int i = 0; i < 1024; i++) if (bus_mem[i] !== ref_mem[i]) chk("mem_final", bus_mem[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
